// File: rtl/riscv_nn_rf_wb_arbiter.sv
// Writeback arbiter for the dual-write-port register file: round-robin grant of up
// to two producers per cycle, registered RF write ports, and a per-register pending scoreboard.
module riscv_nn_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic [ADDR_WIDTH-1:0]            waddr_a_o,
    output logic [DATA_WIDTH-1:0]            wdata_a_o,
    output logic                             we_a_o,
    output logic [ADDR_WIDTH-1:0]            waddr_b_o,
    output logic [DATA_WIDTH-1:0]            wdata_b_o,
    output logic                             we_b_o,
    input  logic                             rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    output logic [(2**ADDR_WIDTH)-1:0]       pending_o
);
    localparam int NUM_WORDS = 2**ADDR_WIDTH;
    localparam int IDX_W     = $clog2(NUM_REQ);

    logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic                  a_fill, b_fill;
    logic [IDX_W-1:0]      a_idx, b_idx;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr;
    logic [DATA_WIDTH-1:0] a_data, b_data;
    logic [NUM_REQ-1:0]    ready;
    logic [NUM_WORDS-1:0]  pending_q, pending_nxt;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1))
            return '0;
        return idx + 1'b1;
    endfunction

    // Circular scan from rr_ptr; slot b skips any requester targeting slot a's register.
    always_comb begin : grant
        int k;
        k      = 0;
        ready  = '0;
        a_fill = 1'b0;
        b_fill = 1'b0;
        a_idx  = '0;
        b_idx  = '0;
        a_addr = '0;
        b_addr = '0;
        a_data = '0;
        b_data = '0;
        if (en_i && !rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                k = int'(rr_ptr) + i;
                if (k >= NUM_REQ)
                    k = k - NUM_REQ;
                if (req_valid_i[k]) begin
                    if (!a_fill) begin
                        a_fill   = 1'b1;
                        a_idx    = IDX_W'(k);
                        a_addr   = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                        a_data   = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                        ready[k] = 1'b1;
                    end else if (!b_fill && req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] != a_addr) begin
                        b_fill   = 1'b1;
                        b_idx    = IDX_W'(k);
                        b_addr   = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                        b_data   = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                        ready[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (b_fill)
            rr_ptr_nxt = wrap_inc(b_idx);
        else if (a_fill)
            rr_ptr_nxt = wrap_inc(a_idx);
    end

    // Clears track the writes the RF commits this edge; a same-edge reserve wins.
    always_comb begin
        pending_nxt = pending_q;
        if (we_a_o)
            pending_nxt[waddr_a_o] = 1'b0;
        if (we_b_o)
            pending_nxt[waddr_b_o] = 1'b0;
        if (rsv_valid_i)
            pending_nxt[rsv_addr_i] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            pending_q <= '0;
            we_a_o    <= 1'b0;
            we_b_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
            waddr_b_o <= '0;
            wdata_b_o <= '0;
        end else begin
            rr_ptr    <= rr_ptr_nxt;
            pending_q <= pending_nxt;
            we_a_o    <= a_fill && (a_addr != '0);
            we_b_o    <= b_fill && (b_addr != '0);
            if (a_fill) begin
                waddr_a_o <= a_addr;
                wdata_a_o <= a_data;
            end
            if (b_fill) begin
                waddr_b_o <= b_addr;
                wdata_b_o <= b_data;
            end
        end
    end

    assign req_ready_o = ready;
    assign pending_o   = pending_q;

endmodule
